// File: rtl/pio_gpio_irq_if.sv
// Avalon-MM slave bus bundle for the GPIO port: the CPU side drives it, the PIO answers.
interface pio_gpio_irq_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_gpio_irq.sv
// WIDTH-bit GPIO with per-bit direction, synchronised inputs, edge capture and a maskable irq.
// Define PIO_GPIO_BITSET_EN to enable the outset (addr 4) / outclear (addr 5) registers.

// One I/O bit: input synchroniser, previous-value flop and the sticky edge-capture bit.
module pio_gpio_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  input  logic clr_i,
  output logic sync_o,
  output logic cap_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cap_q, cap_d;
  logic                   edge_d;

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign cap_o  = cap_q;

  if (EDGE_TYPE == 0) begin : g_rise
    assign edge_d = sync_o & ~prev_q;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign edge_d = ~sync_o & prev_q;
  end else begin : g_any
    assign edge_d = sync_o ^ prev_q;
  end

  // A new edge wins over a clear-write landing in the same cycle.
  assign cap_d = (cap_q & ~clr_i) | edge_d;

  // Chain and prev both reset to 0, so a pin already high at release is one real edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cap_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_o;
      cap_q  <= cap_d;
    end
  end
endmodule

module pio_gpio_irq #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_gpio_irq_if.slave      bus,
  input  logic [WIDTH-1:0]   in_port_i,
  output logic [WIDTH-1:0]   out_port_o,
  output logic [WIDTH-1:0]   oe_o,
  output logic               irq_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, mask_q;
  logic             irq_q;
  logic [WIDTH-1:0] sync_in, edge_cap, cap_clr;
  logic [WIDTH-1:0] rdata_d;
  logic             wr;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign cap_clr = (wr && bus.address == 3'd3) ? bus.writedata : '0;

  pio_gpio_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_lane [WIDTH-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (in_port_i),
    .clr_i   (cap_clr),
    .sync_o  (sync_in),
    .cap_o   (edge_cap)
  );

  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (bus.address)
        3'd0:    data_d = bus.writedata;
`ifdef PIO_GPIO_BITSET_EN
        3'd4:    data_d = data_q | bus.writedata;
        3'd5:    data_d = data_q & ~bus.writedata;
`endif
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      if (wr && bus.address == 3'd1) dir_q  <= bus.writedata;
      if (wr && bus.address == 3'd2) mask_q <= bus.writedata;
      irq_q <= |(edge_cap & mask_q);
    end
  end

  // Zero-wait-state read mux; chipselect is deliberately ignored.
  always_comb begin
    rdata_d = '0;
    case (bus.address)
      3'd0:    rdata_d = (dir_q & data_q) | (~dir_q & sync_in);
      3'd1:    rdata_d = dir_q;
      3'd2:    rdata_d = mask_q;
      3'd3:    rdata_d = edge_cap;
      default: rdata_d = '0;
    endcase
  end

  assign bus.readdata = rdata_d;
  assign out_port_o   = data_q;
  assign oe_o         = dir_q;
  assign irq_o        = irq_q;
endmodule

// File: tb/tb_pio_gpio_irq.sv
// Bench for pio_gpio_irq: register table, directed edge/irq/reset sequences, random run vs model.
module tb_pio_gpio_irq;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int ET = 0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port, out_port, oe;
  logic         irq;

  pio_gpio_irq_if #(.WIDTH(W)) bus ();

  pio_gpio_irq #(
    .WIDTH(W), .RESET_VALUE(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(ET), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .in_port_i(in_port),
    .out_port_o(out_port), .oe_o(oe), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state for the random phase
  logic [7:0] m_data, m_dir, m_mask, m_cap;
  logic       m_irq;
  logic [7:0] hist [0:3];

  typedef struct {
    logic [2:0] wa; logic we; logic [7:0] wd;
    logic [2:0] ra; logic [7:0] rd; logic [7:0] out; logic [7:0] oe; logic irq;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic chk_rd(input string name, input logic [2:0] a, input logic [7:0] exp);
    bus.address = a; #1;
    chk(name, bus.readdata, exp);
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return (m_dir & m_data) | (~m_dir & hist[S-1]);
      3'd1: return m_dir;
      3'd2: return m_mask;
      3'd3: return m_cap;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_data = 8'hA5; m_dir = 8'h0F; m_mask = 8'h00; m_cap = 8'h00; m_irq = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 8'h00;
  endtask

  // One clock of the reference: sync_in is the pin sampled S edges ago, prev one edge earlier.
  task automatic m_step();
    logic [7:0] s, p, e;
    logic       we;
    s = hist[S-1]; p = hist[S];
    case (ET)
      0: e = s & ~p;
      1: e = ~s & p;
      default: e = s ^ p;
    endcase
    we    = bus.chipselect && !bus.write_n;
    m_irq = |(m_cap & m_mask);
    if (we && bus.address == 3'd3) m_cap = m_cap & ~bus.writedata;
    m_cap = m_cap | e;
    if (we) begin
      case (bus.address)
        3'd0: m_data = bus.writedata;
        3'd1: m_dir  = bus.writedata;
        3'd2: m_mask = bus.writedata;
`ifdef PIO_GPIO_BITSET_EN
        3'd4: m_data = m_data | bus.writedata;
        3'd5: m_data = m_data & ~bus.writedata;
`endif
        default: ;
      endcase
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = in_port;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_set, exp_clr;
    //            wa    we    wd     ra    rd     out    oe     irq
    tbl[0] = '{3'd0, 1'b1, 8'h3C, 3'd0, 8'hFC, 8'h3C, 8'h0F, 1'b0};
    tbl[1] = '{3'd3, 1'b1, 8'hF0, 3'd3, 8'h00, 8'h3C, 8'h0F, 1'b0};
    tbl[2] = '{3'd1, 1'b1, 8'hFF, 3'd0, 8'h3C, 8'h3C, 8'hFF, 1'b0};
    tbl[3] = '{3'd1, 1'b1, 8'h00, 3'd0, 8'hF0, 8'h3C, 8'h00, 1'b0};
    tbl[4] = '{3'd2, 1'b1, 8'h5A, 3'd2, 8'h5A, 8'h3C, 8'h00, 1'b0};
    tbl[5] = '{3'd6, 1'b1, 8'hFF, 3'd6, 8'h00, 8'h3C, 8'h00, 1'b0};
    tbl[6] = '{3'd2, 1'b1, 8'h00, 3'd7, 8'h00, 8'h3C, 8'h00, 1'b0};
    tbl[7] = '{3'd0, 1'b0, 8'h00, 3'd0, 8'hF0, 8'h3C, 8'h00, 1'b0};

    // reset state
    reset_n = 1'b0; in_port = 8'hF0;
    bus.address = 3'd3; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 8'h00;
    #12;
    chk("rst_out", out_port, 8'hA5);
    chk("rst_oe", oe, 8'h0F);
    chk("rst_irq", irq, 1'b0);
    chk_rd("rst_cap", 3'd3, 8'h00);
    chk_rd("rst_data_rd", 3'd0, 8'h05);
    #3 reset_n = 1'b1;
    tick(); tick(); tick();
    chk_rd("release_cap", 3'd3, 8'hF0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we) wr(tbl[i].wa, tbl[i].wd);
      else tick();
      chk_rd($sformatf("tbl%0d_rd", i), tbl[i].ra, tbl[i].rd);
      chk($sformatf("tbl%0d_out", i), out_port, tbl[i].out);
      chk($sformatf("tbl%0d_oe", i), oe, tbl[i].oe);
      chk($sformatf("tbl%0d_irq", i), irq, tbl[i].irq);
    end

    // rising edge on bit 0: capture at k+2, irq at k+3, clear drops irq one clk later
    in_port = 8'h00;
    wr(3'd2, 8'h01);
    tick(); tick(); tick();
    in_port = 8'h01;
    tick(); chk_rd("e_k0_cap", 3'd3, 8'h00);
    tick(); chk_rd("e_k1_cap", 3'd3, 8'h00);
    tick(); chk_rd("e_k2_cap", 3'd3, 8'h01); chk("e_k2_irq", irq, 1'b0);
    tick(); chk("e_k3_irq", irq, 1'b1);
    wr(3'd3, 8'h01);
    chk_rd("clr_cap", 3'd3, 8'h00); chk("clr_irq_hold", irq, 1'b1);
    tick(); chk("clr_irq_fall", irq, 1'b0);

    // clear-write colliding with a new edge on bit 2
    in_port = 8'h05;
    tick(); tick();
    wr(3'd3, 8'h04);
    chk_rd("collide_cap", 3'd3, 8'h04);
    wr(3'd3, 8'h04);
    chk_rd("reclear_cap", 3'd3, 8'h00);

    // masked capture, then unmask
    wr(3'd2, 8'h00);
    in_port = 8'h85;
    tick(); tick(); tick();
    chk_rd("mask_cap", 3'd3, 8'h80);
    tick(); chk("masked_irq0", irq, 1'b0);
    tick(); chk("masked_irq1", irq, 1'b0);
    wr(3'd2, 8'h80); chk("unmask_irq0", irq, 1'b0);
    tick(); chk("unmask_irq1", irq, 1'b1);

    // bit set / bit clear
    wr(3'd3, 8'h80); wr(3'd2, 8'h00);
    wr(3'd0, 8'h0F);
    chk("bs_base", out_port, 8'h0F);
`ifdef PIO_GPIO_BITSET_EN
    exp_set = 8'h3F; exp_clr = 8'h3C;
`else
    exp_set = 8'h0F; exp_clr = 8'h0F;
`endif
    wr(3'd4, 8'h30); chk("bs_set", out_port, exp_set);
    chk_rd("bs_rd4", 3'd4, 8'h00);
    wr(3'd5, 8'h03); chk("bs_clr", out_port, exp_clr);
    chk_rd("bs_rd5", 3'd5, 8'h00);

    // asynchronous reset mid-run, release with all pins high
    wr(3'd2, 8'hFF);
    in_port = 8'h00;
    tick(); tick(); tick(); tick();
    in_port = 8'hFF;
    tick(); tick(); tick();
    chk_rd("pre_rst_cap", 3'd3, 8'hFF);
    tick(); chk("pre_rst_irq", irq, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_irq", irq, 1'b0);
    chk("arst_out", out_port, 8'hA5);
    chk("arst_oe", oe, 8'h0F);
    chk_rd("arst_cap", 3'd3, 8'h00);
    chk_rd("arst_mask", 3'd2, 8'h00);
    @(negedge clk); reset_n = 1'b1;
    tick(); chk_rd("rel_e1_cap", 3'd3, 8'h00);
    tick(); chk_rd("rel_e2_cap", 3'd3, 8'h00);
    tick(); chk_rd("rel_e3_cap", 3'd3, 8'hFF);
    wr(3'd3, 8'hFF);
    tick(); tick(); tick();
    chk_rd("rel_once_cap", 3'd3, 8'h00);
    chk("rel_irq", irq, 1'b0);

    // randomized run against the reference model
    @(negedge clk);
    reset_n = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      bus.chipselect = ($urandom_range(0, 3) == 0);
      bus.write_n    = ($urandom_range(0, 1) == 0);
      bus.address    = 3'($urandom_range(0, 7));
      bus.writedata  = 8'($urandom);
      if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
      #2;
      chk($sformatf("rnd%0d_rd", n), bus.readdata, m_read(bus.address));
      chk($sformatf("rnd%0d_out", n), out_port, m_data);
      chk($sformatf("rnd%0d_oe", n), oe, m_dir);
      chk($sformatf("rnd%0d_irq", n), irq, m_irq);
      @(posedge clk);
      m_step();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
